// File: rtl/hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// hs_ram_arbiter
//
// Shares the single-port work RAM between the Z80 CPU and the hiscore
// save/restore engine. A hiscore read/write intent halts the CPU through
// cpu_wait. Once the (synchronised) halt acknowledge has been stable for
// HOLD_WAIT further cycles, the RAM port is handed to the hiscore engine.
// When the intents drop, one DRAIN cycle with no write separates the hiscore
// ownership from the CPU regaining the port.
//
// Ports
//   clk_sys, reset_n          : system clock, asynchronous active-low reset
//   cpu_addr/din/we, cpu_dout : CPU side of the RAM port (cpu_dout = ram_dout)
//   cpu_wait                  : hold request to the CPU
//   cpu_halted                : CPU halt acknowledge (asynchronous, synchronised)
//   hs_address/data_in/write_enable, hs_read_intent, hs_write_intent
//                             : hiscore engine request side
//   hs_data_out               : registered RAM read data to the hiscore engine
//   hs_granted                : hiscore engine owns the RAM
//   hs_timeout                : sticky acknowledge-timeout flag
//   ram_addr/din/we, ram_dout : work-RAM port (ram_dout valid 1 cycle after addr)
// ---------------------------------------------------------------------------
module hs_ram_arbiter #(
  parameter int AW        = 11,
  parameter int DW        = 8,
  parameter int HOLD_WAIT = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  input  logic          cpu_we,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_wait,
  input  logic          cpu_halted,
  input  logic [AW-1:0] hs_address,
  input  logic [DW-1:0] hs_data_in,
  input  logic          hs_write_enable,
  input  logic          hs_read_intent,
  input  logic          hs_write_intent,
  output logic [DW-1:0] hs_data_out,
  output logic          hs_granted,
  output logic          hs_timeout,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  localparam logic [1:0] ST_CPU   = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_GRANT = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [3:0] HOLD_WAIT_C = 4'(HOLD_WAIT);
  // The timeout counter starts at 0 on HOLD entry, so the last allowed
  // un-acknowledged HOLD cycle is TIMEOUT-1.
  localparam logic [7:0] TO_LAST_C   = 8'(TIMEOUT - 1);

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          sync1_r;
  logic          halted_q_r;
  logic [3:0]    wait_cnt_r;
  logic [3:0]    wait_cnt_nxt_s;
  logic [7:0]    to_cnt_r;
  logic [7:0]    to_cnt_nxt_s;
  logic          timeout_r;
  logic          timeout_nxt_s;
  logic [DW-1:0] data_out_r;
  logic          intent_s;

  assign intent_s = hs_read_intent | hs_write_intent;

  // Two-flop synchroniser for the asynchronous halt acknowledge.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r    <= 1'b0;
      halted_q_r <= 1'b0;
    end else begin
      sync1_r    <= cpu_halted;
      halted_q_r <= sync1_r;
    end
  end

  // Ownership FSM next-state, settle counter and timeout counter.
  always_comb begin
    state_nxt_s    = state_r;
    wait_cnt_nxt_s = wait_cnt_r;
    to_cnt_nxt_s   = to_cnt_r;
    timeout_nxt_s  = timeout_r;
    case (state_r)
      ST_CPU: begin
        // A timed-out engine is locked out until the next reset.
        if (intent_s && !timeout_r) begin
          state_nxt_s    = ST_HOLD;
          wait_cnt_nxt_s = 4'd0;
          to_cnt_nxt_s   = 8'd0;
        end else begin
          state_nxt_s = ST_CPU;
        end
      end
      ST_HOLD: begin
        if (!intent_s) begin
          state_nxt_s = ST_CPU;
        end else if (halted_q_r) begin
          if (wait_cnt_r == HOLD_WAIT_C) begin
            state_nxt_s = ST_GRANT;
          end else begin
            wait_cnt_nxt_s = wait_cnt_r + 4'd1;
          end
        end else if (to_cnt_r == TO_LAST_C) begin
          timeout_nxt_s = 1'b1;
          state_nxt_s   = ST_CPU;
        end else begin
          to_cnt_nxt_s = to_cnt_r + 8'd1;
        end
      end
      ST_GRANT: begin
        // Losing the acknowledge here does not revoke the grant.
        if (!intent_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_GRANT;
        end
      end
      ST_DRAIN: begin
        state_nxt_s = ST_CPU;
      end
      default: begin
        state_nxt_s = ST_CPU;
      end
    endcase
  end

  // State, counters and sticky timeout flag.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= ST_CPU;
      wait_cnt_r <= 4'd0;
      to_cnt_r   <= 8'd0;
      timeout_r  <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_cnt_nxt_s;
      to_cnt_r   <= to_cnt_nxt_s;
      timeout_r  <= timeout_nxt_s;
    end
  end

  // Hiscore read data: captured every GRANT cycle, held otherwise.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      data_out_r <= '0;
    end else if (state_r == ST_GRANT) begin
      data_out_r <= ram_dout;
    end else begin
      data_out_r <= data_out_r;
    end
  end

  // RAM port mux, selected by state only. HOLD keeps the CPU connected so
  // an in-flight CPU write still completes; DRAIN blocks all writes.
  always_comb begin
    ram_addr = cpu_addr;
    ram_din  = cpu_din;
    ram_we   = 1'b0;
    case (state_r)
      ST_CPU, ST_HOLD: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = cpu_we;
      end
      ST_GRANT: begin
        ram_addr = hs_address;
        ram_din  = hs_data_in;
        ram_we   = hs_write_enable & hs_write_intent;
      end
      ST_DRAIN: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
      end
      default: begin
        ram_addr = cpu_addr;
        ram_din  = cpu_din;
        ram_we   = 1'b0;
      end
    endcase
  end

  assign cpu_dout    = ram_dout;
  assign cpu_wait    = (state_r != ST_CPU);
  assign hs_granted  = (state_r == ST_GRANT);
  assign hs_timeout  = timeout_r;
  assign hs_data_out = data_out_r;

endmodule

// File: tb/tb_hs_ram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hs_ram_arbiter
//
// Directed bench for hs_ram_arbiter (default parameters). Stimulus schedules
// expected values into a scoreboard keyed by cycle number; a monitor on the
// falling clock edge pops and compares every entry due in that cycle.
// A behavioural synchronous RAM (read-first, 1-cycle read latency) sits on
// the ram_* port.
// ---------------------------------------------------------------------------
module tb_hs_ram_arbiter;

  localparam int SIG_WAIT    = 0;
  localparam int SIG_GRANTED = 1;
  localparam int SIG_TIMEOUT = 2;
  localparam int SIG_HS_DOUT = 3;
  localparam int SIG_CPUDOUT = 4;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic [10:0] cpu_addr;
  logic [7:0]  cpu_din;
  logic        cpu_we;
  logic [7:0]  cpu_dout;
  logic        cpu_wait;
  logic        cpu_halted;
  logic [10:0] hs_address;
  logic [7:0]  hs_data_in;
  logic        hs_write_enable;
  logic        hs_read_intent;
  logic        hs_write_intent;
  logic [7:0]  hs_data_out;
  logic        hs_granted;
  logic        hs_timeout;
  logic [10:0] ram_addr;
  logic [7:0]  ram_din;
  logic        ram_we;
  logic [7:0]  ram_dout;

  logic [7:0]  mem [0:2047];

  int cycle_cnt = 0;
  int checks    = 0;
  int failures  = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] exp;
    string       name;
  } exp_t;

  exp_t sb_q[$];

  hs_ram_arbiter #(
    .AW(11), .DW(8), .HOLD_WAIT(4), .TIMEOUT(255)
  ) dut (
    .clk_sys         (clk_sys),
    .reset_n         (reset_n),
    .cpu_addr        (cpu_addr),
    .cpu_din         (cpu_din),
    .cpu_we          (cpu_we),
    .cpu_dout        (cpu_dout),
    .cpu_wait        (cpu_wait),
    .cpu_halted      (cpu_halted),
    .hs_address      (hs_address),
    .hs_data_in      (hs_data_in),
    .hs_write_enable (hs_write_enable),
    .hs_read_intent  (hs_read_intent),
    .hs_write_intent (hs_write_intent),
    .hs_data_out     (hs_data_out),
    .hs_granted      (hs_granted),
    .hs_timeout      (hs_timeout),
    .ram_addr        (ram_addr),
    .ram_din         (ram_din),
    .ram_we          (ram_we),
    .ram_dout        (ram_dout)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) cycle_cnt <= cycle_cnt + 1;

  // Work RAM model; cleared while reset is held.
  always @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 8'h00;
      ram_dout <= 8'h00;
    end else begin
      if (ram_we) mem[ram_addr] <= ram_din;
      ram_dout <= mem[ram_addr];
    end
  end

  function automatic logic [31:0] observe(input int sig);
    case (sig)
      SIG_WAIT:    observe = {31'd0, cpu_wait};
      SIG_GRANTED: observe = {31'd0, hs_granted};
      SIG_TIMEOUT: observe = {31'd0, hs_timeout};
      SIG_HS_DOUT: observe = {24'd0, hs_data_out};
      SIG_CPUDOUT: observe = {24'd0, cpu_dout};
      default:     observe = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: compare every scoreboard entry due in the current cycle.
  always @(negedge clk_sys) begin
    for (int i = sb_q.size() - 1; i >= 0; i--) begin
      if (sb_q[i].cyc <= cycle_cnt) begin
        checks = checks + 1;
        if (observe(sb_q[i].sig) !== sb_q[i].exp) begin
          failures = failures + 1;
          $display("FAIL %s (cycle %0d): got %0h, expected %0h",
                   sb_q[i].name, cycle_cnt, observe(sb_q[i].sig), sb_q[i].exp);
        end
        sb_q.delete(i);
      end
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic expect_at(input int d, input int sig, input logic [31:0] e,
                           input string nm);
    exp_t item;
    item.cyc  = cycle_cnt + d;
    item.sig  = sig;
    item.exp  = e;
    item.name = nm;
    sb_q.push_back(item);
  endtask

  task automatic cpu_write(input logic [10:0] a, input logic [7:0] d);
    cpu_addr = a;
    cpu_din  = d;
    cpu_we   = 1'b1;
    step();
    cpu_we   = 1'b0;
  endtask

  task automatic cpu_read(input logic [10:0] a, input logic [7:0] e,
                          input string nm);
    cpu_addr = a;
    step();
    expect_at(0, SIG_CPUDOUT, {24'd0, e}, nm);
  endtask

  initial begin
    reset_n = 1'b0; cpu_addr = 11'd0; cpu_din = 8'd0; cpu_we = 1'b0;
    cpu_halted = 1'b0; hs_address = 11'd0; hs_data_in = 8'd0;
    hs_write_enable = 1'b0; hs_read_intent = 1'b0; hs_write_intent = 1'b0;
    repeat (3) step();
    reset_n = 1'b1;
    expect_at(0, SIG_WAIT,    32'd0, "rst_cpu_wait");
    expect_at(0, SIG_GRANTED, 32'd0, "rst_hs_granted");
    expect_at(0, SIG_TIMEOUT, 32'd0, "rst_hs_timeout");
    expect_at(0, SIG_HS_DOUT, 32'd0, "rst_hs_data_out");
    step();

    // Grant latency: halt ack 3 cycles after intent, grant 7 cycles after ack.
    hs_read_intent = 1'b1;
    expect_at(0, SIG_WAIT, 32'd0, "wait_before_hold");
    expect_at(1, SIG_WAIT, 32'd1, "wait_rise");
    repeat (3) step();
    cpu_halted = 1'b1;
    expect_at(6, SIG_GRANTED, 32'd0, "grant_not_early");
    expect_at(7, SIG_GRANTED, 32'd1, "grant_latency");
    repeat (7) step();

    // Hiscore write 0xA5 @0x040 with a concurrent CPU write that must be blocked.
    hs_write_intent = 1'b1; hs_address = 11'h040; hs_data_in = 8'hA5;
    hs_write_enable = 1'b1;
    cpu_addr = 11'h040; cpu_din = 8'h77; cpu_we = 1'b1;
    step();
    hs_write_enable = 1'b0; cpu_we = 1'b0;
    expect_at(1, SIG_HS_DOUT, 32'h00, "hs_read_old");
    expect_at(2, SIG_HS_DOUT, 32'hA5, "hs_read_data");
    repeat (2) step();

    // Release: DRAIN for one cycle, then CPU.
    hs_read_intent = 1'b0; hs_write_intent = 1'b0; cpu_halted = 1'b0;
    expect_at(0, SIG_GRANTED, 32'd1, "release_granted_hold");
    expect_at(1, SIG_GRANTED, 32'd0, "release_granted_drop");
    expect_at(1, SIG_WAIT,    32'd1, "release_drain_wait");
    expect_at(2, SIG_WAIT,    32'd0, "release_wait_low");
    repeat (2) step();
    cpu_write(11'h0AB, 8'h3C);
    cpu_read(11'h0AB, 8'h3C, "cpu_write_after_release");
    cpu_read(11'h040, 8'hA5, "cpu_we_blocked_in_grant");
    repeat (3) step();

    // Abort in HOLD, with a CPU write issued in the same cycle as the intent.
    hs_write_intent = 1'b1;
    cpu_addr = 11'h011; cpu_din = 8'h99; cpu_we = 1'b1;
    expect_at(1, SIG_WAIT, 32'd1, "abort_wait_rise");
    step();
    cpu_we = 1'b0;
    step();
    hs_write_intent = 1'b0;
    expect_at(0, SIG_WAIT,    32'd1, "abort_still_hold");
    expect_at(1, SIG_WAIT,    32'd0, "abort_wait_low");
    expect_at(1, SIG_TIMEOUT, 32'd0, "abort_no_timeout");
    expect_at(1, SIG_GRANTED, 32'd0, "abort_no_grant");
    repeat (2) step();
    cpu_read(11'h011, 8'h99, "simultaneous_cpu_write");

    // Reset while granted: outputs clear before any clock edge.
    hs_read_intent = 1'b1; cpu_halted = 1'b1; hs_address = 11'h040;
    expect_at(7, SIG_GRANTED, 32'd1, "grant_again");
    repeat (8) step();
    reset_n = 1'b0;
    expect_at(0, SIG_GRANTED, 32'd0, "rst_async_granted");
    expect_at(0, SIG_WAIT,    32'd0, "rst_async_wait");
    expect_at(0, SIG_HS_DOUT, 32'd0, "rst_async_hs_dout");
    hs_read_intent = 1'b0; cpu_halted = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    step();
    cpu_write(11'h123, 8'h5A);
    cpu_read(11'h123, 8'h5A, "cpu_rw_after_reset");

    // Timeout: intent held, no acknowledge.
    hs_read_intent = 1'b1;
    expect_at(200, SIG_WAIT,    32'd1, "timeout_still_hold");
    expect_at(200, SIG_TIMEOUT, 32'd0, "timeout_not_early");
    expect_at(260, SIG_TIMEOUT, 32'd1, "timeout_set");
    expect_at(260, SIG_WAIT,    32'd0, "timeout_wait_low");
    repeat (262) step();
    hs_read_intent = 1'b0;
    repeat (2) step();
    hs_write_intent = 1'b1; cpu_halted = 1'b1;
    expect_at(10, SIG_WAIT,    32'd0, "timeout_ignores_intent");
    expect_at(10, SIG_GRANTED, 32'd0, "timeout_no_grant");
    expect_at(10, SIG_TIMEOUT, 32'd1, "timeout_sticky");
    repeat (12) step();

    checks = checks + 1;
    if (sb_q.size() != 0) begin
      failures = failures + 1;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hs_ram_arbiter.md
# hs_ram_arbiter

Shares the game's single-port work RAM between the Z80 CPU and the hiscore save/restore engine. When the hiscore engine raises a read or write intent, the block halts the CPU through its wait/hold input and waits for the CPU's halt acknowledge. It then hands the RAM port to the hiscore engine and returns ownership to the CPU once the intents drop. It sits between the CPU bus decode and the work-RAM instance, in the `clk_sys` domain.

## Interface
Parameters:
- `AW`, 11: RAM address width.
- `DW`, 8: RAM data width.
- `HOLD_WAIT`, 4: settle cycles counted after halt acknowledge before grant; legal range 0..15.
- `TIMEOUT`, 255: maximum cycles spent in HOLD waiting for acknowledge; legal range 1..255.

Ports:
- `clk_sys`  in  1  system clock; sole clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `cpu_addr`  in  AW  CPU RAM address.
- `cpu_din`  in  DW  CPU write data.
- `cpu_we`  in  1  CPU RAM write strobe, one `clk_sys` cycle per write.
- `cpu_dout`  out  DW  RAM read data to the CPU; equals `ram_dout`, combinational.
- `cpu_wait`  out  1  hold request to the CPU (to the BUSRQ/WAIT logic).
- `cpu_halted`  in  1  CPU halt acknowledge; asynchronous to the bus phase; sampled registered.
- `hs_address`  in  AW  hiscore RAM address; low AW bits used.
- `hs_data_in`  in  DW  hiscore write data.
- `hs_write_enable`  in  1  hiscore write strobe.
- `hs_read_intent`  in  1  hiscore requests read access.
- `hs_write_intent`  in  1  hiscore requests write access.
- `hs_data_out`  out  DW  registered RAM read data to hiscore.
- `hs_granted`  out  1  high while the hiscore engine owns the RAM.
- `hs_timeout`  out  1  sticky; set on acknowledge timeout.
- `ram_addr`  out  AW  RAM address.
- `ram_din`  out  DW  RAM write data.
- `ram_we`  out  1  RAM write enable.
- `ram_dout`  in  DW  RAM read data; valid 1 cycle after `ram_addr`.

## Operation
- `intent` = `hs_read_intent | hs_write_intent`.
- `halted_q` is `cpu_halted` passed through a 2-flop synchronizer.

States and transitions:
- **CPU**
  - RAM mux selects `cpu_*`; `ram_we` = `cpu_we`.
  - Exit: `intent` → HOLD. The wait counter and timeout counter clear.
- **HOLD**
  - `cpu_wait`=1; RAM mux still selects the CPU, so an in-flight CPU write completes.
  - `cpu_we` is still passed through in this state.
  - Once `halted_q`=1, the wait counter increments; when it reaches HOLD_WAIT → GRANT.
  - `intent` drops → CPU; `cpu_wait` deasserts the next cycle.
  - Timeout counter reaches TIMEOUT with `halted_q`=0 → set `hs_timeout`, go to CPU. While `hs_timeout`=1, further intents are ignored until reset.
- **GRANT**
  - `cpu_wait`=1, `hs_granted`=1.
  - RAM mux selects `hs_*`; `ram_we` = `hs_write_enable & hs_write_intent`; `cpu_we` is ignored.
  - `hs_data_out` <= `ram_dout` every cycle.
  - Exit: `intent`=0 → DRAIN.
- **DRAIN**
  - One cycle: `ram_we`=0, mux selects the CPU, `cpu_wait` stays 1, `hs_granted`=0.
  - Always → CPU.
- In CPU state `hs_data_out` holds its last value.
- `halted_q` dropping during GRANT does not revoke the grant; the hiscore engine keeps ownership until its intents drop.

## Timing
- Reset values (asynchronous, immediate on `reset_n`=0, including mid-GRANT):
  - state=CPU, `cpu_wait`=0, `hs_granted`=0, `hs_timeout`=0, `hs_data_out`=0.
  - Counters 0, synchronizer flops 0.
- `cpu_wait` rises 1 cycle after the first cycle `intent` is high.
- Grant latency: `hs_granted` rises HOLD_WAIT+1 cycles after the first cycle `halted_q`=1. This is 3+HOLD_WAIT cycles after `cpu_halted` rises.
- Hiscore read latency: address presented at cycle T in GRANT → `hs_data_out` valid at T+2.
- Hiscore write: written at the same edge as `hs_write_enable`.
- Release: `intent` falls at T → DRAIN at T+1 → CPU at T+2; `cpu_wait`=0 from T+2.
- Simultaneous `intent` and `cpu_we` in CPU state: the CPU write is performed that cycle.
- All outputs except `cpu_dout` are registered or decoded from state only. `ram_*` mux outputs are decoded from state.

## Test plan
- Reset mid-GRANT:
  - Force GRANT, pulse `reset_n` low → `hs_granted`=0 and `cpu_wait`=0 with no clock edge.
  - After release, CPU writes 0x5A to 0x123 and reads 0x5A back.
- Grant latency (HOLD_WAIT=4):
  - Raise `hs_read_intent`, then raise `cpu_halted` 3 cycles later.
  - → `cpu_wait` at +1; `hs_granted` exactly 7 cycles after `cpu_halted` rises.
- Hiscore round trip:
  - In GRANT, write 0xA5 to 0x040, then read 0x040 → `hs_data_out`=0xA5 two cycles after the read address.
  - `cpu_we` pulsed during GRANT must not alter RAM.
- Release:
  - Drop both intents → `hs_granted` low next cycle; `cpu_wait` low 2 cycles after the drop.
  - CPU write then lands in RAM.
- Abort and timeout:
  - Intent dropped in HOLD before acknowledge → back to CPU, `hs_timeout`=0.
  - Intent held with `cpu_halted`=0 for 255 cycles → `hs_timeout`=1, `cpu_wait`=0; a new intent is ignored.
